// File: rtl/op_dispatcher_if.sv
// Shared-memory client port used by the op dispatcher.
//   req/we/addr/wdata : request, held until the gnt cycle
//   gnt               : request accepted this cycle
//   rdata/rvalid      : read return, one or more cycles after a read grant
interface op_dispatcher_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req;
    logic                  gnt;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rdata, rvalid
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rdata, rvalid
    );
endinterface

// File: rtl/op_dispatcher.sv
// Command sequencer for the matrix accelerator: polls the op word, fetches
// dimensions (and scalar when needed), launches the engine, waits for done
// under a watchdog, then clears the op word so the host can issue the next.
// Ports:
//   clock, reset   : clock, async active-low reset
//   enable         : allows IDLE -> FETCH_OP
//   mem            : shared-memory client port (master side)
//   op_code, dimA1, dimA2, scalar : latched command for the engine
//   start / done   : engine launch pulse / completion pulse
//   abort, error   : one-cycle pulses on watchdog expiry / rejected command
//   busy           : high outside IDLE
//   ops_done       : saturating count of completed commands
module op_dispatcher #(
    parameter int unsigned ADDR_WIDTH    = 12,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OP_WIDTH      = 4,
    parameter int unsigned DIM_WIDTH     = 6,
    parameter int unsigned OP_ADDR       = 0,
    parameter int unsigned DIM_ADDR      = 1,
    parameter int unsigned SCALAR_ADDR   = 10,
    parameter int unsigned TIMEOUT_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    op_dispatcher_if.master       mem,
    output logic [OP_WIDTH-1:0]   op_code,
    output logic [DIM_WIDTH-1:0]  dimA1,
    output logic [DIM_WIDTH-1:0]  dimA2,
    output logic [DATA_WIDTH-1:0] scalar,
    output logic                  start,
    input  logic                  done,
    output logic                  abort,
    output logic                  error,
    output logic                  busy,
    output logic [15:0]           ops_done
);
    localparam int unsigned OP_MAX     = 8;
    localparam int unsigned OP_SCAL_LO = 2;
    localparam int unsigned OP_SCAL_HI = 5;
    localparam int unsigned DIM2_LSB   = 8;

    typedef enum logic [3:0] {
        IDLE, FETCH_OP, WAIT_OP, FETCH_DIM, WAIT_DIM,
        FETCH_SCAL, WAIT_SCAL, START, RUN, CLEAR
    } state_t;

    state_t                   state;
    logic [TIMEOUT_WIDTH-1:0] wd;

    // Field views of the returning read word
    logic [OP_WIDTH-1:0]  rd_op_c;
    logic [DIM_WIDTH-1:0] rd_dim1_c;
    logic [DIM_WIDTH-1:0] rd_dim2_c;
    logic                 needs_scalar_c;

    assign rd_op_c        = mem.rdata[OP_WIDTH-1:0];
    assign rd_dim1_c      = mem.rdata[DIM_WIDTH-1:0];
    assign rd_dim2_c      = mem.rdata[DIM2_LSB +: DIM_WIDTH];
    assign needs_scalar_c = (op_code >= OP_WIDTH'(OP_SCAL_LO)) &&
                            (op_code <= OP_WIDTH'(OP_SCAL_HI));

    // Sequencer: state, memory request and all outputs registered together
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wd        <= '0;
            mem.req   <= 1'b0;
            mem.we    <= 1'b0;
            mem.addr  <= '0;
            mem.wdata <= '0;
            op_code   <= '0;
            dimA1     <= '0;
            dimA2     <= '0;
            scalar    <= '0;
            start     <= 1'b0;
            abort     <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b0;
            ops_done  <= '0;
        end else begin
            start <= 1'b0;
            abort <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= FETCH_OP;
                        busy     <= 1'b1;
                        mem.req  <= 1'b1;
                        mem.we   <= 1'b0;
                        mem.addr <= ADDR_WIDTH'(OP_ADDR);
                    end
                end
                FETCH_OP, FETCH_DIM, FETCH_SCAL: begin
                    if (mem.gnt) begin
                        mem.req <= 1'b0;
                        state   <= (state == FETCH_OP)  ? WAIT_OP  :
                                   (state == FETCH_DIM) ? WAIT_DIM : WAIT_SCAL;
                    end
                end
                WAIT_OP: begin
                    if (mem.rvalid) begin
                        if (rd_op_c == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (rd_op_c > OP_WIDTH'(OP_MAX)) begin
                            error     <= 1'b1;
                            state     <= CLEAR;
                            mem.req   <= 1'b1;
                            mem.we    <= 1'b1;
                            mem.addr  <= ADDR_WIDTH'(OP_ADDR);
                            mem.wdata <= '0;
                        end else begin
                            op_code  <= rd_op_c;
                            state    <= FETCH_DIM;
                            mem.req  <= 1'b1;
                            mem.addr <= ADDR_WIDTH'(DIM_ADDR);
                        end
                    end
                end
                WAIT_DIM: begin
                    if (mem.rvalid) begin
                        dimA1 <= rd_dim1_c;
                        dimA2 <= rd_dim2_c;
                        if ((rd_dim1_c == '0) || (rd_dim2_c == '0)) begin
                            error     <= 1'b1;
                            state     <= CLEAR;
                            mem.req   <= 1'b1;
                            mem.we    <= 1'b1;
                            mem.addr  <= ADDR_WIDTH'(OP_ADDR);
                            mem.wdata <= '0;
                        end else if (needs_scalar_c) begin
                            state    <= FETCH_SCAL;
                            mem.req  <= 1'b1;
                            mem.addr <= ADDR_WIDTH'(SCALAR_ADDR);
                        end else begin
                            scalar <= '0;
                            state  <= START;
                        end
                    end
                end
                WAIT_SCAL: begin
                    if (mem.rvalid) begin
                        scalar <= mem.rdata;
                        state  <= START;
                    end
                end
                START: begin
                    // Watchdog counts RUN cycles from 1; all-ones marks 2^W-1 cycles
                    start <= 1'b1;
                    wd    <= TIMEOUT_WIDTH'(1);
                    state <= RUN;
                end
                RUN: begin
                    if (done || (wd == '1)) begin
                        if (done) begin
                            if (ops_done != '1) begin
                                ops_done <= ops_done + 16'(1);
                            end
                        end else begin
                            abort <= 1'b1;
                            error <= 1'b1;
                        end
                        state     <= CLEAR;
                        mem.req   <= 1'b1;
                        mem.we    <= 1'b1;
                        mem.addr  <= ADDR_WIDTH'(OP_ADDR);
                        mem.wdata <= '0;
                    end else begin
                        wd <= wd + TIMEOUT_WIDTH'(1);
                    end
                end
                CLEAR: begin
                    if (mem.gnt) begin
                        mem.req <= 1'b0;
                        mem.we  <= 1'b0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    mem.req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_op_dispatcher.sv
// Bench for op_dispatcher: memory slave with configurable grant delay and
// read latency, engine model driving done, and a command-level reference.
module tb_op_dispatcher;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = 8;
    localparam int TMAX = (1 << TW) - 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        done = 1'b0;
    logic [3:0]  op_code;
    logic [5:0]  dimA1, dimA2;
    logic [31:0] scalar;
    logic        start, abort, error, busy;
    logic [15:0] ops_done;

    op_dispatcher_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem ();

    op_dispatcher #(.TIMEOUT_WIDTH(TW)) dut (
        .clock(clock), .reset(reset), .enable(enable), .mem(mem),
        .op_code(op_code), .dimA1(dimA1), .dimA2(dimA2), .scalar(scalar),
        .start(start), .done(done), .abort(abort), .error(error),
        .busy(busy), .ops_done(ops_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] op_word, dim_word, scal_word;
        int          gdly, rlat, ddly;
        int          n_start, n_err, n_abort, inc;
        logic [3:0]  e_op;
        logic [5:0]  e_d1, e_d2;
        logic [31:0] e_scal;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_arr [0:15];
    int cyc = 0, gnt_dly = 0, rd_lat = 1, done_dly = -1, done_cnt = 0;
    int req_age = 0, rd_cnt = 0;
    logic rd_pend = 1'b0, granted_last = 1'b0, dim_granted = 1'b0;
    logic [31:0] rd_data;
    logic [AW-1:0] cap_addr;
    logic cap_we;
    logic [DW-1:0] cap_wdata;
    int n_start = 0, n_err = 0, n_abort = 0, n_clear = 0, n_op_reads = 0, n_rvalid = 0;
    int start_cyc = 0, abort_cyc = 0, op_req_cyc = 0, lat = 0;
    logic [3:0]  s_op;
    logic [5:0]  s_d1, s_d2;
    logic [31:0] s_scal;
    logic [15:0] exp_ops_done = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] ow, dw, sw, input int g, r, d,
                                input int ns, ne, na, inc, input logic [3:0] eo,
                                input logic [5:0] e1, e2, input logic [31:0] es);
        vec_t v;
        v.op_word = ow; v.dim_word = dw; v.scal_word = sw;
        v.gdly = g; v.rlat = r; v.ddly = d;
        v.n_start = ns; v.n_err = ne; v.n_abort = na; v.inc = inc;
        v.e_op = eo; v.e_d1 = e1; v.e_d2 = e2; v.e_scal = es;
        return v;
    endfunction

    // Command-level reference: what one nonzero op word should produce
    function automatic vec_t model(input logic [31:0] ow, dw, sw, input int g, r, d);
        vec_t v;
        logic [3:0] op;
        logic [5:0] a1, a2;
        v = mk(ow, dw, sw, g, r, d, 0, 0, 0, 0, 4'd0, 6'd0, 6'd0, 32'd0);
        op = ow[3:0];
        a1 = dw[5:0];
        a2 = dw[13:8];
        if (op > 4'd8 || a1 == 6'd0 || a2 == 6'd0) begin
            v.n_err = 1;
        end else begin
            v.n_start = 1; v.e_op = op; v.e_d1 = a1; v.e_d2 = a2;
            v.e_scal = (op >= 4'd2 && op <= 4'd5) ? sw : 32'd0;
            if (d >= 0 && d <= TMAX - 1) v.inc = 1;
            else begin v.n_err = 1; v.n_abort = 1; end
        end
        return v;
    endfunction

    // Memory slave, engine model and pulse monitor, all on the falling edge
    initial begin
        mem.gnt = 1'b0; mem.rvalid = 1'b0; mem.rdata = '0;
        forever begin
            @(negedge clock);
            cyc++;
            mem.gnt = 1'b0; mem.rvalid = 1'b0; mem.rdata = $urandom(); done = 1'b0;
            if (start) begin
                n_start++; start_cyc = cyc; lat = cyc - op_req_cyc;
                s_op = op_code; s_d1 = dimA1; s_d2 = dimA2; s_scal = scalar;
                if (done_dly == 0) done = 1'b1;
                else if (done_dly > 0) done_cnt = done_dly;
            end else if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) done = 1'b1;
            end
            if (error) n_err++;
            if (abort) begin n_abort++; abort_cyc = cyc; end
            if (!reset) req_age = 0;
            if (granted_last) check("req_drop_after_gnt", 32'(mem.req), 32'd0);
            granted_last = 1'b0;
            if (rd_pend) begin
                if (rd_cnt == 0) begin
                    mem.rvalid = 1'b1; mem.rdata = rd_data; rd_pend = 1'b0; n_rvalid++;
                end else rd_cnt--;
            end else if (mem.req && reset) begin
                if (req_age == 0) begin
                    cap_addr = mem.addr; cap_we = mem.we; cap_wdata = mem.wdata;
                    if (mem.addr == '0 && !mem.we) begin op_req_cyc = cyc; n_op_reads++; end
                end else begin
                    check("req_fields_stable",
                          32'(mem.addr == cap_addr && mem.we == cap_we && mem.wdata == cap_wdata), 32'd1);
                end
                if (req_age >= gnt_dly) begin
                    mem.gnt = 1'b1; granted_last = 1'b1; req_age = 0;
                    if (mem.we) begin
                        if (mem.addr < 16) mem_arr[mem.addr[3:0]] = mem.wdata;
                        if (mem.addr == '0) n_clear++;
                    end else begin
                        rd_pend = 1'b1; rd_cnt = rd_lat - 1;
                        rd_data = (mem.addr < 16) ? mem_arr[mem.addr[3:0]] : 32'hBAD0BAD0;
                        if (mem.addr == AW'(1)) dim_granted = 1'b1;
                    end
                end else req_age++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string name, input bit hold_en);
        int guard, nreads, base;
        mem_arr[0] = v.op_word; mem_arr[1] = v.dim_word; mem_arr[10] = v.scal_word;
        gnt_dly = v.gdly; rd_lat = v.rlat; done_dly = v.ddly; done_cnt = 0;
        n_start = 0; n_err = 0; n_abort = 0; n_clear = 0;
        base = n_op_reads;
        tick();
        enable = 1'b1;
        guard = 0;
        if (hold_en) begin
            while (n_start == 0 && n_clear == 0 && guard < 1000) begin tick(); guard++; end
        end else begin
            while (n_op_reads == base && guard < 50) begin tick(); guard++; end
        end
        enable = 1'b0;
        guard = 0;
        while (!(n_clear > 0 && busy == 1'b0) && guard < 1000) begin tick(); guard++; end
        check({name, "_completes"}, 32'(guard < 1000), 32'd1);
        repeat (3) tick();
        if (v.inc != 0 && exp_ops_done != 16'hFFFF) exp_ops_done = exp_ops_done + 16'd1;
        check({name, "_starts"}, 32'(n_start), 32'(v.n_start));
        check({name, "_errors"}, 32'(n_err), 32'(v.n_err));
        check({name, "_aborts"}, 32'(n_abort), 32'(v.n_abort));
        check({name, "_clears"}, 32'(n_clear), 32'd1);
        check({name, "_opword"}, mem_arr[0], 32'd0);
        check({name, "_ops_done"}, 32'(ops_done), 32'(exp_ops_done));
        if (v.n_start != 0) begin
            nreads = (v.e_op >= 4'd2 && v.e_op <= 4'd5) ? 3 : 2;
            check({name, "_op_code"}, 32'(s_op), 32'(v.e_op));
            check({name, "_dimA1"}, 32'(s_d1), 32'(v.e_d1));
            check({name, "_dimA2"}, 32'(s_d2), 32'(v.e_d2));
            check({name, "_scalar"}, s_scal, v.e_scal);
            check({name, "_latency"}, 32'(lat), 32'(nreads * (v.gdly + 1 + v.rlat) + 1));
            check({name, "_op_held"}, 32'(op_code), 32'(v.e_op));
        end
        if (v.n_abort != 0) check({name, "_abort_time"}, 32'(abort_cyc - start_cyc), 32'(TMAX));
        base = n_op_reads;
        repeat (6) tick();
        check({name, "_stays_idle"}, 32'({busy, 31'(n_op_reads - base)}), 32'd0);
    endtask

    initial begin
        vec_t tbl[10];
        vec_t v;
        int base, guard;
        logic [31:0] ow, dw;
        logic ok;

        tbl[0] = mk(32'h1, 32'h0204, 32'hDEAD, 0, 1, 20, 1, 0, 0, 1, 4'd1, 6'd4, 6'd2, 32'd0);
        tbl[1] = mk(32'h2, 32'h0305, 32'h40000000, 3, 2, 10, 1, 0, 0, 1, 4'd2, 6'd5, 6'd3, 32'h40000000);
        tbl[2] = mk(32'h9, 32'h0101, 32'h0, 0, 1, 5, 0, 1, 0, 0, 4'd0, 6'd0, 6'd0, 32'd0);
        tbl[3] = mk(32'h1, 32'h0004, 32'h0, 1, 1, 5, 0, 1, 0, 0, 4'd0, 6'd0, 6'd0, 32'd0);
        tbl[4] = mk(32'h6, 32'h0500, 32'h0, 0, 2, 5, 0, 1, 0, 0, 4'd0, 6'd0, 6'd0, 32'd0);
        tbl[5] = mk(32'h7, 32'h0101, 32'h5, 1, 1, -1, 1, 1, 1, 0, 4'd7, 6'd1, 6'd1, 32'd0);
        tbl[6] = mk(32'h3, 32'h3F3F, 32'h12345678, 0, 1, TMAX - 1, 1, 0, 0, 1, 4'd3, 6'd63, 6'd63, 32'h12345678);
        tbl[7] = mk(32'h8, 32'hFFFF2A15, 32'h7, 2, 3, 3, 1, 0, 0, 1, 4'd8, 6'd21, 6'd42, 32'd0);
        tbl[8] = mk(32'h1, 32'h0101, 32'h0, 0, 1, TMAX, 1, 1, 1, 0, 4'd1, 6'd1, 6'd1, 32'd0);
        tbl[9] = mk(32'hFFF00005, 32'h0102, 32'd99, 0, 1, 0, 1, 0, 0, 1, 4'd5, 6'd2, 6'd1, 32'd99);

        for (int i = 0; i < 16; i++) mem_arr[i] = 32'd0;
        mem.gnt = 1'b0; mem.rvalid = 1'b0;
        #1;
        check("reset_outputs", {op_code, dimA1, dimA2, start, abort, error, busy, 13'd0}, 32'd0);
        check("reset_scalar_count", {scalar[15:0], ops_done}, 32'd0);
        check("reset_req", 32'(mem.req), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i), i == 0);

        // Op word 0: continuous polling, nothing launched
        mem_arr[0] = 32'd0; gnt_dly = 0; rd_lat = 1;
        n_start = 0; n_clear = 0; base = n_op_reads;
        enable = 1'b1;
        repeat (30) tick();
        enable = 1'b0;
        repeat (5) tick();
        check("poll_count", 32'((n_op_reads - base) >= 9 && (n_op_reads - base) <= 11), 32'd1);
        check("poll_no_start", 32'(n_start + n_clear), 32'd0);
        check("poll_idle", 32'(busy), 32'd0);

        // Reset in WAIT_DIM with a stray read return arriving after release
        mem_arr[0] = 32'h1; mem_arr[1] = 32'h0304; gnt_dly = 0; rd_lat = 8;
        dim_granted = 1'b0; done_dly = 5;
        enable = 1'b1;
        guard = 0;
        while (!dim_granted && guard < 50) begin tick(); guard++; end
        enable = 1'b0;
        tick();
        check("wait_dim_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("async_reset_busy", {busy, ops_done, op_code}, 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        base = n_rvalid;
        ok = 1'b1;
        n_start = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy || start || mem.req || error) ok = 1'b0;
        end
        check("stray_rvalid_seen", 32'(n_rvalid > base), 32'd1);
        check("stray_ignored", 32'({ok, n_start == 0}), 32'd3);
        check("post_reset_regs", {op_code, dimA1, dimA2, ops_done}, 32'd0);
        check("post_reset_scalar", scalar, 32'd0);
        exp_ops_done = 16'd0;
        run_vec(tbl[0], "resume", 1'b0);

        // Randomized commands against the reference model
        for (int i = 0; i < 16; i++) begin
            ow = $urandom();
            ow[3:0] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(1, 8));
            dw = $urandom();
            if ($urandom_range(0, 5) == 0) dw[5:0] = 6'd0;
            if ($urandom_range(0, 5) == 0) dw[13:8] = 6'd0;
            v = model(ow, dw, $urandom(), $urandom_range(0, 3), $urandom_range(1, 3),
                      ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 40));
            run_vec(v, $sformatf("rand%0d", i), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "time limit");
    end
endmodule
